// File: rtl/serial_add_ctrl.sv
// Bit-serial WIDTH-bit add/subtract sequencer around a single 1-bit add cell.
// It latches the operands on start and runs the cell LSB first for WIDTH cycles.
// It then presents a registered sum/carry together with a one-cycle done pulse.
module serial_add_ctrl #(
   parameter int unsigned WIDTH = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic             sub,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] sum,
   output logic             co
);

   localparam int unsigned CW = $clog2(WIDTH) + 1;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_DONE = 2'd2
   } state_e;

   state_e           state_q, state_d;
   logic [WIDTH-1:0] opa_q, opa_d;
   logic [WIDTH-1:0] opb_q, opb_d;
   logic [WIDTH-1:0] res_q, res_d;
   logic [WIDTH-1:0] sum_q, sum_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic             carry_q, carry_d;
   logic             co_q, co_d;
   logic             busy_q, busy_d;
   logic             done_q, done_d;

   logic             p_bit;
   logic             s_bit;
   logic             cy_bit;
   logic [WIDTH-1:0] res_shift;

   // Add cell, sequencing and next-state/output decode
   always_comb begin
      state_d = state_q;
      opa_d   = opa_q;
      opb_d   = opb_q;
      res_d   = res_q;
      sum_d   = sum_q;
      cnt_d   = cnt_q;
      carry_d = carry_q;
      co_d    = co_q;

      // Two half-adder stages plus the carry flop form the 1-bit cell
      p_bit     = opa_q[0] ^ opb_q[0];
      s_bit     = p_bit ^ carry_q;
      cy_bit    = (opa_q[0] & opb_q[0]) | (p_bit & carry_q);
      res_shift = (res_q >> 1) | (WIDTH'(s_bit) << (WIDTH - 1));

      case (state_q)
         S_IDLE: begin
            if (start) begin
               state_d = S_RUN;
               opa_d   = a;
               opb_d   = sub ? ~b : b;
               carry_d = sub;
               cnt_d   = '0;
            end
         end
         S_RUN: begin
            carry_d = cy_bit;
            res_d   = res_shift;
            opa_d   = opa_q >> 1;
            opb_d   = opb_q >> 1;
            cnt_d   = cnt_q + CW'(1);
            if (cnt_q == CW'(WIDTH - 1)) begin
               state_d = S_DONE;
               sum_d   = res_shift;
               co_d    = cy_bit;
            end
         end
         S_DONE: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase

      busy_d = (state_d != S_IDLE);
      done_d = (state_d == S_DONE);
   end

   // State and datapath registers; synchronous reset aborts any operation
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_IDLE;
         opa_q   <= '0;
         opb_q   <= '0;
         res_q   <= '0;
         sum_q   <= '0;
         cnt_q   <= '0;
         carry_q <= 1'b0;
         co_q    <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         opa_q   <= opa_d;
         opb_q   <= opb_d;
         res_q   <= res_d;
         sum_q   <= sum_d;
         cnt_q   <= cnt_d;
         carry_q <= carry_d;
         co_q    <= co_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
      end
   end

   assign busy = busy_q;
   assign done = done_q;
   assign sum  = sum_q;
   assign co   = co_q;

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Self-checking bench for serial_add_ctrl at WIDTH=4: vector table, random ops, corner sequences.
module tb_serial_add_ctrl;

   localparam int unsigned W = 4;

   logic         clk = 1'b0;
   logic         rst;
   logic         start;
   logic         sub;
   logic [W-1:0] a;
   logic [W-1:0] b;
   logic         busy;
   logic         done;
   logic [W-1:0] sum;
   logic         co;

   int n_chk  = 0;
   int n_fail = 0;

   serial_add_ctrl #(.WIDTH(W)) dut (
      .clk   (clk),
      .rst   (rst),
      .start (start),
      .sub   (sub),
      .a     (a),
      .b     (b),
      .busy  (busy),
      .done  (done),
      .sum   (sum),
      .co    (co)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [W-1:0] a;
      logic [W-1:0] b;
      logic         sub;
      logic [W-1:0] exp_sum;
      logic         exp_co;
   } vec_t;

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, got, exp);
      end
   endtask

   // Reference: plain modular arithmetic; co is carry-out for add, no-borrow for subtract
   function automatic logic [W:0] ref_op(input logic [W-1:0] x, input logic [W-1:0] y, input logic s);
      int unsigned xi, yi, r;
      xi = int'(x);
      yi = int'(y);
      if (s) r = (xi + (1 << W) - yi);
      else   r = xi + yi;
      return (W+1)'(r);
   endfunction

   // One operation: pulse start, scramble inputs while running, measure latency and busy span
   task automatic do_op(input logic [W-1:0] ta, input logic [W-1:0] tb_in, input logic ts,
                        output logic [W-1:0] rs, output logic rc, output int lat,
                        output int bcnt, output bit ok, output logic dn_after);
      @(negedge clk);
      a = ta; b = tb_in; sub = ts; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      lat = 1; bcnt = 0; ok = 1'b0; rs = '0; rc = 1'b0;
      for (int i = 0; i < 20; i++) begin
         if (busy) bcnt++;
         if (done) begin
            ok = 1'b1; rs = sum; rc = co;
            break;
         end
         a = W'($urandom); b = W'($urandom); sub = 1'($urandom);
         @(negedge clk);
         lat++;
      end
      @(negedge clk);
      if (busy) bcnt++;
      dn_after = done;
   endtask

   task automatic check_op(input string tag, input logic [W-1:0] ta, input logic [W-1:0] tb_in,
                           input logic ts, input logic [W-1:0] es, input logic ec);
      logic [W-1:0] rs;
      logic rc, dn_after;
      int lat, bcnt;
      bit ok;
      do_op(ta, tb_in, ts, rs, rc, lat, bcnt, ok, dn_after);
      chk({tag, ".done_seen"}, 32'(ok), 32'd1);
      chk({tag, ".sum"}, 32'(rs), 32'(es));
      chk({tag, ".co"}, 32'(rc), 32'(ec));
      chk({tag, ".latency"}, 32'(lat), 32'(W + 1));
      chk({tag, ".busy_cycles"}, 32'(bcnt), 32'(W + 1));
      chk({tag, ".done_pulse"}, 32'(dn_after), 32'd0);
   endtask

   initial begin
      vec_t vecs[$];
      logic [W:0] r;
      logic [W-1:0] ra, rb;
      logic rsub;

      rst = 1'b1; start = 1'b1; sub = 1'b0; a = 4'd3; b = 4'd4;

      // Reset dominates start
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("rst.busy", 32'(busy), 32'd0);
      chk("rst.done", 32'(done), 32'd0);
      chk("rst.sum", 32'(sum), 32'd0);
      chk("rst.co", 32'(co), 32'd0);
      start = 1'b0;
      rst = 1'b0;
      @(negedge clk);
      chk("rst.idle_after", 32'(busy), 32'd0);

      // Directed vector table
      vecs.push_back('{4'd7,  4'd9,  1'b0, 4'h0, 1'b1});
      vecs.push_back('{4'd5,  4'd3,  1'b1, 4'h2, 1'b1});
      vecs.push_back('{4'd3,  4'd5,  1'b1, 4'hE, 1'b0});
      vecs.push_back('{4'd15, 4'd15, 1'b0, 4'hE, 1'b1});
      vecs.push_back('{4'd2,  4'd2,  1'b0, 4'h4, 1'b0});
      vecs.push_back('{4'd0,  4'd0,  1'b1, 4'h0, 1'b1});
      vecs.push_back('{4'd8,  4'd15, 1'b1, 4'h9, 1'b0});
      vecs.push_back('{4'd15, 4'd0,  1'b1, 4'hF, 1'b1});
      vecs.push_back('{4'd0,  4'd0,  1'b0, 4'h0, 1'b0});
      vecs.push_back('{4'd15, 4'd1,  1'b0, 4'h0, 1'b1});
      for (int i = 0; i < vecs.size(); i++)
         check_op($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, vecs[i].sub,
                  vecs[i].exp_sum, vecs[i].exp_co);

      // Random operations against the arithmetic model
      for (int i = 0; i < 40; i++) begin
         ra = W'($urandom); rb = W'($urandom); rsub = 1'($urandom);
         r = ref_op(ra, rb, rsub);
         check_op($sformatf("rnd%0d", i), ra, rb, rsub, r[W-1:0], r[W]);
      end

      // Start held high: one op every W+2 cycles, never restarted mid-run
      @(negedge clk);
      a = 4'd1; b = 4'd1; sub = 1'b0; start = 1'b1;
      for (int c = 1; c <= 30; c++) begin
         @(negedge clk);
         chk($sformatf("hold.busy%0d", c), 32'(busy), 32'((c % (W + 2)) != 0));
         chk($sformatf("hold.done%0d", c), 32'(done), 32'((c % (W + 2)) == W + 1));
         if (done) chk($sformatf("hold.sum%0d", c), 32'(sum), 32'd2);
      end
      start = 1'b0;
      @(negedge clk);

      // Reset in the third RUN cycle aborts without a done pulse
      @(negedge clk);
      a = 4'd7; b = 4'd8; sub = 1'b0; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      @(negedge clk);
      chk("abort.sum_held", 32'(sum), 32'(ref_op(4'd1, 4'd1, 1'b0)));
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      chk("abort.sum_clr", 32'(sum), 32'd0);
      chk("abort.co_clr", 32'(co), 32'd0);
      chk("abort.busy", 32'(busy), 32'd0);
      begin
         int dn = 0;
         for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            if (done) dn++;
         end
         chk("abort.no_done", 32'(dn), 32'd0);
      end
      check_op("after_abort", 4'd2, 4'd2, 1'b0, 4'h4, 1'b0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
